// File: rtl/mdr_sequencer_pkg.sv
// mdr_sequencer_pkg
// Shared types and helpers for the multiply/divide/square-root control
// sequencer: operation codes, FSM state encoding and the per-operation
// iteration count.
package mdr_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_Y,
    S_ARMED,
    S_RUN,
    S_DONE,
    S_ERROR
  } seq_state_e;

  // Number of accumulator iterations for an operation on n-bit operands.
  // Square root produces n/2 result bits, so it needs half the cycles.
  // The illegal code never reaches RUN; it maps to n only to stay in range.
  function automatic int unsigned iter_of(input logic [1:0] op, input int unsigned n);
    if (op == OP_SQRT) begin
      return n / 2;
    end
    return n;
  endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// mdr_iter_counter
// Iteration counter for the AQ accumulator run.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear to zero (takes priority over en)
//   en    : advance one step per cycle while below term
//   term  : terminal value (ITER-1); the counter saturates there
//   count : current iteration index
//   last  : high while enabled on the terminal value
module mdr_iter_counter #(
  parameter int C = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [C:0] term,
  output logic [C:0] count,
  output logic       last
);

  logic [C:0] count_q;
  logic [C:0] count_d;

  // Holding at term (rather than wrapping) keeps count valid on the
  // final cycle, when the FSM is already leaving RUN.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != term)) begin
      count_d = count_q + {{C{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = en && (count_q == term);

endmodule

// File: rtl/mdr_sequencer.sv
// mdr_sequencer
// Control FSM for the multiply/divide/square-root datapath. Steers load
// pulses into the X and Y operand registers, latches the op code, checks
// operands on start and runs the iteration counter that enables AQ.
//   clk, rst        : clock, asynchronous active-low reset
//   load, start     : debounced single-cycle pulses
//   op, data        : op select (sampled on first load), operand bus (Y zero check)
//   load_x, load_y  : operand register write enables (combinational)
//   op_q            : latched op to datapath muxes
//   acc_clr, acc_en : AQ first-iteration select and enable
//   count, last     : iteration index and final-iteration flag
//   loaded_x/y      : operand-captured indicators
//   busy, ready, error : status
module mdr_sequencer
  import mdr_sequencer_pkg::*;
#(
  parameter int N = 16,
  parameter int C = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] data,
  output logic         load_x,
  output logic         load_y,
  output logic [1:0]   op_q,
  output logic         acc_clr,
  output logic         acc_en,
  output logic [C:0]   count,
  output logic         last,
  output logic         loaded_x,
  output logic         loaded_y,
  output logic         busy,
  output logic         ready,
  output logic         error
);

  localparam int CW = C + 1;

  seq_state_e state_q, state_d;
  logic [1:0] op_latch_q, op_latch_d;
  logic       loaded_x_q, loaded_x_d;
  logic       loaded_y_q, loaded_y_d;
  logic       y_zero_q, y_zero_d;

  logic       load_x_c, load_y_c, acc_clr_c, ready_c;
  logic       run_w, last_w;
  logic [C:0] term_w;

  assign run_w  = (state_q == S_RUN);
  assign term_w = CW'(iter_of(op_latch_q, N) - 1);

  mdr_iter_counter #(.C(C)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr_c),
    .en    (run_w),
    .term  (term_w),
    .count (count),
    .last  (last_w)
  );

  always_comb begin
    state_d    = state_q;
    op_latch_d = op_latch_q;
    loaded_x_d = loaded_x_q;
    loaded_y_d = loaded_y_q;
    y_zero_d   = y_zero_q;
    load_x_c   = 1'b0;
    load_y_c   = 1'b0;
    acc_clr_c  = 1'b0;
    ready_c    = 1'b0;
    case (state_q)
      // DONE accepts a new operation exactly like IDLE; load beats start.
      S_IDLE, S_DONE: begin
        ready_c = (state_q == S_DONE);
        if (load) begin
          load_x_c   = 1'b1;
          op_latch_d = op;
          loaded_x_d = 1'b1;
          loaded_y_d = 1'b0;
          state_d    = (op == OP_SQRT) ? S_ARMED : S_WAIT_Y;
        end else if (start && (state_q == S_DONE)) begin
          // Re-run on the held operands; ready drops with the clear pulse.
          acc_clr_c = 1'b1;
          ready_c   = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_WAIT_Y: begin
        if (load) begin
          load_y_c   = 1'b1;
          y_zero_d   = (data == '0);
          loaded_y_d = 1'b1;
          state_d    = S_ARMED;
        end
      end
      // A load arriving here is dropped; start always takes precedence.
      S_ARMED: begin
        if (start) begin
          if ((op_latch_q == OP_ILL) || ((op_latch_q == OP_DIV) && y_zero_q)) begin
            state_d = S_ERROR;
          end else begin
            acc_clr_c = 1'b1;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_w) begin
          state_d = S_DONE;
        end
      end
      // The clearing load is swallowed: no X write on the way back to IDLE.
      S_ERROR: begin
        if (load) begin
          loaded_x_d = 1'b0;
          loaded_y_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_latch_q <= 2'b00;
      loaded_x_q <= 1'b0;
      loaded_y_q <= 1'b0;
      y_zero_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_latch_q <= op_latch_d;
      loaded_x_q <= loaded_x_d;
      loaded_y_q <= loaded_y_d;
      y_zero_q   <= y_zero_d;
    end
  end

  // Combinational strobes are gated by reset so every output reads 0
  // while rst is held low, even if a pulse is present.
  assign load_x   = rst & load_x_c;
  assign load_y   = rst & load_y_c;
  assign acc_clr  = rst & acc_clr_c;
  assign ready    = rst & ready_c;
  assign last     = rst & last_w;
  assign acc_en   = run_w;
  assign busy     = run_w;
  assign error    = (state_q == S_ERROR);
  assign op_q     = op_latch_q;
  assign loaded_x = loaded_x_q;
  assign loaded_y = loaded_y_q;

endmodule

// File: tb/tb_mdr_sequencer.sv
module tb_mdr_sequencer;
  import mdr_sequencer_pkg::*;

  localparam int N = 16;
  localparam int C = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] data = '0;
  logic         load_x, load_y, acc_clr, acc_en, last;
  logic         loaded_x, loaded_y, busy, ready, error;
  logic [1:0]   op_q;
  logic [C:0]   count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int run_cnt = 0;
  int acc_total = 0;
  int acc_snap = 0;
  logic ready_prev = 1'b0;

  mdr_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .start(start), .op(op), .data(data),
    .load_x(load_x), .load_y(load_y), .op_q(op_q), .acc_clr(acc_clr),
    .acc_en(acc_en), .count(count), .last(last), .loaded_x(loaded_x),
    .loaded_y(loaded_y), .busy(busy), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({load_x, load_y, op_q, acc_clr, acc_en, count, last,
                loaded_x, loaded_y, busy, ready, error});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] o, input logic [N-1:0] d,
                         input logic ex, input logic ey, input string tag);
    op = o; data = d; load = 1'b1;
    #1;
    chk({tag, "_load_x"}, 32'(load_x), 32'(ex));
    chk({tag, "_load_y"}, 32'(load_y), 32'(ey));
    step();
    load = 1'b0;
  endtask

  task automatic do_start(input logic ex_clr, input string tag);
    start = 1'b1;
    #1;
    chk({tag, "_acc_clr"}, 32'(acc_clr), 32'(ex_clr));
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    step();
  endtask

  // Scoreboard side: measures each run and compares against the queued length.
  initial forever begin
    @(negedge clk);
    if (acc_clr) run_cnt = 0;
    if (acc_en) begin
      acc_total++;
      if (exp_q.size() > 0) begin
        chk("run_count", 32'(count), 32'(run_cnt));
        chk("run_last", 32'(last), 32'(run_cnt == exp_q[0] - 1));
      end
      run_cnt++;
    end
    if (ready && !ready_prev) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        $display("run complete: op_q=%0d acc_en_cycles=%0d expected=%0d", op_q, run_cnt, exp_q[0]);
        chk("run_len", 32'(run_cnt), 32'(exp_q.pop_front()));
      end
    end
    ready_prev = ready;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("reset_outs", all_outs(), 32'd0);
    step();
    rst = 1'b1;
    step();

    // 1: MUL 7*3; op on the second load must be ignored
    do_load(2'b00, 16'd7, 1'b1, 1'b0, "mul_x");
    chk("mul_loaded_x", 32'(loaded_x), 32'd1);
    do_load(2'b11, 16'd3, 1'b0, 1'b1, "mul_y");
    chk("mul_loaded_y", 32'(loaded_y), 32'd1);
    chk("mul_op_q", 32'(op_q), 32'd0);
    exp_q.push_back(N);
    do_start(1'b1, "mul");
    wait_ready("mul");
    chk("mul_busy_done", 32'(busy), 32'd0);

    // 2: SQRT straight from DONE
    do_load(2'b10, 16'd144, 1'b1, 1'b0, "sqrt_x");
    chk("sqrt_ready_drop", 32'(ready), 32'd0);
    chk("sqrt_loaded_y", 32'(loaded_y), 32'd0);
    exp_q.push_back(N / 2);
    do_start(1'b1, "sqrt");
    wait_ready("sqrt");
    chk("sqrt_loaded_y_end", 32'(loaded_y), 32'd0);

    // 3: DIV by zero
    do_load(2'b01, 16'd9, 1'b1, 1'b0, "dz_x");
    do_load(2'b00, 16'd0, 1'b0, 1'b1, "dz_y");
    acc_snap = acc_total;
    do_start(1'b0, "dz");
    chk("dz_error", 32'(error), 32'd1);
    do_start(1'b0, "dz_err_start");
    step();
    chk("dz_error_held", 32'(error), 32'd1);
    chk("dz_no_acc", 32'(acc_total), 32'(acc_snap));
    do_load(2'b00, 16'd5, 1'b0, 1'b0, "dz_clear");
    chk("dz_cleared", 32'({error, loaded_x, loaded_y}), 32'd0);
    do_start(1'b0, "idle_start");

    // 4: illegal op
    do_load(2'b11, 16'd1, 1'b1, 1'b0, "ill_x");
    do_load(2'b00, 16'd2, 1'b0, 1'b1, "ill_y");
    do_start(1'b0, "ill");
    chk("ill_error", 32'(error), 32'd1);
    do_load(2'b00, 16'd1, 1'b0, 1'b0, "ill_clear");
    chk("ill_cleared", 32'(error), 32'd0);

    // 5: DIV, load+start together in ARMED (start wins), pulses in RUN ignored
    do_load(2'b01, 16'd100, 1'b1, 1'b0, "div_x");
    do_load(2'b00, 16'd7, 1'b0, 1'b1, "div_y");
    exp_q.push_back(N);
    load = 1'b1; start = 1'b1;
    #1;
    chk("armed_both_clr", 32'(acc_clr), 32'd1);
    chk("armed_both_ldx", 32'({load_x, load_y}), 32'd0);
    step();
    load = 1'b0; start = 1'b0;
    step();
    do_load(2'b10, 16'd0, 1'b0, 1'b0, "run_ld");
    do_start(1'b0, "run_st");
    chk("run_busy", 32'(busy), 32'd1);
    wait_ready("div");
    chk("div_op_q", 32'(op_q), 32'd1);

    // 6: reset mid-RUN, fresh MUL, then re-run from DONE
    do_load(2'b00, 16'd7, 1'b1, 1'b0, "rr_x");
    do_load(2'b00, 16'd3, 1'b0, 1'b1, "rr_y");
    do_start(1'b1, "rr");
    begin
      int n = 0;
      while (!(busy && count == 5) && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rr_count5", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("rr_reset_outs", all_outs(), 32'd0);
    step();
    rst = 1'b1;
    step();
    do_load(2'b00, 16'd7, 1'b1, 1'b0, "fr_x");
    do_load(2'b00, 16'd3, 1'b0, 1'b1, "fr_y");
    exp_q.push_back(N);
    do_start(1'b1, "fr");
    wait_ready("fr");
    exp_q.push_back(N);
    start = 1'b1;
    #1;
    chk("rerun_ready_drop", 32'(ready), 32'd0);
    chk("rerun_acc_clr", 32'(acc_clr), 32'd1);
    step();
    start = 1'b0;
    wait_ready("rerun");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Control FSM for the multiply/divide/square-root datapath.
- Steers debounced `load` pulses into the X (Q) and Y (M) operand registers and latches the operation code.
- Validates operands, then runs the iteration counter that enables the AQ accumulator register for the op-specific number of cycles.
- Reports ready/error/busy to the top level; replaces the separate load demux, counter and start/stop handshaking glue.

Parameters:
- N, 16, operand width in bits (even, ≥4).
- C, $clog2(N), counter MSB index; count is C+1 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- load  in  1  debounced single-cycle load pulse.
- start  in  1  debounced single-cycle start pulse.
- op  in  2  operation select, sampled on the first load of an operation.
- data  in  N  operand bus, used only for the zero check on Y.
- load_x  out  1  write enable for the X/Q register.
- load_y  out  1  write enable for the Y/M register.
- op_q  out  2  latched op driven to the datapath muxes.
- acc_clr  out  1  selects fresh mix_regs value into AQ (first-iteration select).
- acc_en  out  1  AQ register enable.
- count  out  C+1  current iteration index.
- last  out  1  final-iteration flag (datapath final correction).
- loaded_x  out  1  X captured (LED).
- loaded_y  out  1  Y captured (LED).
- busy  out  1  RUN active.
- ready  out  1  result valid.
- error  out  1  illegal op or divide by zero.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, op_q=00, count=0, y_zero=0.
- Op encoding (package): MUL=00, DIV=01, SQRT=10, 11 illegal.
- ITER: MUL=N, DIV=N, SQRT=N/2.
- States: IDLE, WAIT_Y, ARMED, RUN, DONE, ERROR.
- IDLE:
  - load → load_x=1 combinationally in the same cycle.
  - Latch op_q<=op; loaded_x<=1; loaded_y<=0.
  - Next state ARMED if op==SQRT, else WAIT_Y.
- WAIT_Y:
  - load → load_y=1 same cycle; y_zero<=(data==0); loaded_y<=1; next ARMED.
- ARMED:
  - start → if op_q==11, or op_q==DIV with y_zero=1, go to ERROR.
  - Otherwise acc_clr=1 for that one cycle; count<=0; next RUN.
- RUN:
  - acc_en=1 and busy=1 every cycle; count increments each cycle.
  - last=1 when count==ITER-1; on that cycle next state is DONE and count holds.
  - Exactly ITER RUN cycles.
- DONE:
  - ready=1 held.
  - start → re-run with the same operands: acc_clr pulse, then RUN; ready drops in the acc_clr cycle.
  - load → behaves as the IDLE load (new operation); ready<=0.
- ERROR:
  - error=1 held.
  - load → clears error, loaded_x, loaded_y; returns to IDLE without asserting load_x (that pulse is consumed).
- Latency: start accepted at edge k → RUN cycles k+1..k+ITER → ready=1 from edge k+ITER+1.
- Ignored events:
  - start in IDLE or WAIT_Y.
  - load or start in RUN.
  - start in ERROR.
- Simultaneous load and start in the same cycle: load has priority in IDLE, WAIT_Y and DONE; in ARMED, start wins and load is ignored.
- op changes after latching are ignored until the next operation.
- Reset mid-RUN: immediate return to IDLE, acc_en=0, counter cleared; AQ contents are don't-care.
- count never exceeds ITER-1 (no wrap).

Decomposition:
- Pkg_Global additions:
  - op_e enum (MUL/DIV/SQRT/ILL).
  - seq_state_e enum.
  - function iter_of(op) returning ITER.
- One natural sub-module: mdr_iter_counter (clear, enable, terminal-value compare → count, last).

Test Plan:
1. MUL, N=16: load (op=00, data=7), load (data=3), start → one acc_clr cycle, then acc_en for 16 cycles; last on count=15; ready=1 on the next cycle; load_y seen once.
2. SQRT: load (op=10, data=144), start → no load_y pulse; acc_en for 8 cycles; last at count=7; ready=1; loaded_y=0.
3. DIV by zero: load (op=01, data=9), load (data=0), start → error=1 and acc_en never asserted; next load clears error, state IDLE, load_x=0 that cycle.
4. Illegal op: load (op=11), load, start → error=1.
5. RUN robustness: load and start pulses during RUN (DIV) → ignored; exactly 16 acc_en cycles.
6. Reset mid-RUN (MUL) at count=5: rst low → all outputs 0 asynchronously. After release, a fresh MUL completes in 16 cycles. DONE then start → re-run with acc_clr and 16 more cycles.
